// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pkg
// Brief    : Operation and state encodings shared by the multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam logic [1:0] OP_MULT   = 2'b00;
    localparam logic [1:0] OP_MULTU  = 2'b01;
    localparam logic [1:0] OP_DIV    = 2'b10;
    localparam logic [1:0] OP_DIVU   = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CALC   = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_signfix.sv
`default_nettype none
// ============================================================================
// Module   : mdu_signfix
// Brief    : Combinational conditional two's-complement negate (abs / sign fix).
// Revision : 1.0 - initial release
// ============================================================================
module mdu_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_res
);

    assign o_res = i_neg ? ((~i_val) + W'(1)) : i_val;

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Brief    : Iterative HI/LO multiply/divide engine; define MDU_EARLY_OUT_EN
//            to let multiplies leave CALC once the multiplier is exhausted.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mb_q, mb_d;
    logic               neg_q, neg_d;
    logic               nega_q, nega_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               div0_q, div0_d;

    logic               w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot, w_rem;
    logic [WIDTH:0]     w_diff;
    logic               w_accept, w_start_div0, w_calc_last;

    assign w_a_neg = op_is_signed(op) & a[WIDTH-1];
    assign w_b_neg = op_is_signed(op) & b[WIDTH-1];

    mdu_signfix #(.W(WIDTH))   u_abs_a    (.i_val(a),                    .i_neg(w_a_neg), .o_res(w_mag_a));
    mdu_signfix #(.W(WIDTH))   u_abs_b    (.i_val(b),                    .i_neg(w_b_neg), .o_res(w_mag_b));
    mdu_signfix #(.W(2*WIDTH)) u_fix_prod (.i_val(acc_q),                .i_neg(neg_q),   .o_res(w_prod));
    mdu_signfix #(.W(WIDTH))   u_fix_quot (.i_val(acc_q[WIDTH-1:0]),     .i_neg(neg_q),   .o_res(w_quot));
    mdu_signfix #(.W(WIDTH))   u_fix_rem  (.i_val(acc_q[2*WIDTH-1:WIDTH]), .i_neg(nega_q), .o_res(w_rem));

    assign w_accept     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign w_start_div0 = op_is_div(op) && (b == '0);

    // Restoring-divide trial: shifted partial remainder minus divisor.
    assign w_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mb_q};

`ifdef MDU_EARLY_OUT_EN
    assign w_calc_last = (cnt_q == CNT_LAST) ||
                         (!op_is_div(op_q) && (mb_q[WIDTH-1:1] == '0));
`else
    assign w_calc_last = (cnt_q == CNT_LAST);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            mb_q    <= '0;
            neg_q   <= 1'b0;
            nega_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mb_q    <= mb_d;
            neg_q   <= neg_d;
            nega_q  <= nega_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            div0_q  <= div0_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) state_d = w_start_div0 ? ST_DONE : ST_CALC;
                else       state_d = ST_IDLE;
            end
            ST_CALC:   if (w_calc_last) state_d = ST_FINISH;
            ST_FINISH: state_d = ST_DONE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mb_d    = mb_q;
        neg_d   = neg_q;
        nega_d  = nega_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        div0_d  = 1'b0;
        if (w_accept) begin
            if (w_start_div0) begin
                div0_d = 1'b1;
            end else begin
                op_d    = op;
                cnt_d   = '0;
                acc_d   = op_is_div(op) ? {{WIDTH{1'b0}}, w_mag_a} : '0;
                mcand_d = {{WIDTH{1'b0}}, w_mag_a};
                mb_d    = w_mag_b;
                neg_d   = w_a_neg ^ w_b_neg;
                nega_d  = w_a_neg;
            end
        end else if (state_q == ST_CALC) begin
            cnt_d = cnt_q + CW'(1);
            if (op_is_div(op_q)) begin
                // acc holds {remainder, dividend bits being replaced by quotient bits}
                acc_d = w_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                      : {w_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d   = acc_q + (mb_q[0] ? mcand_q : '0);
                mcand_d = {mcand_q[2*WIDTH-2:0], 1'b0};
                mb_d    = {1'b0, mb_q[WIDTH-1:1]};
            end
        end else if (state_q == ST_FINISH) begin
            if (op_is_div(op_q)) begin
                hi_d = w_rem;
                lo_d = w_quot;
            end else begin
                hi_d = w_prod[2*WIDTH-1:WIDTH];
                lo_d = w_prod[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        busy = (state_q == ST_CALC) || (state_q == ST_FINISH);
        done = (state_q == ST_DONE);
    end

    assign div0 = div0_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
`default_nettype wire
